// File: rtl/clock3_pkg.sv
// Shared types, segment patterns and BCD helpers for the clock3 time-of-day core.
// Time is always held in 24-h BCD form; the 12-h view is derived for display only.
package clock3_pkg;

  localparam int SEG_W    = 7;
  localparam int N_DIGITS = 6;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] HR12_MID_HI = 4'd1;
  localparam logic [3:0] HR12_MID_LO = 4'd2;
  localparam logic [3:0] HR12_SUB_LO = 4'd2;
  localparam logic [3:0] HR12_ADD_LO = 4'd8;

  typedef struct packed {
    logic [3:0] hr_hi;
    logic [3:0] hr_lo;
    logic [3:0] min_hi;
    logic [3:0] min_lo;
    logic [3:0] sec_hi;
    logic [3:0] sec_lo;
  } tod_t;

  // 24-h BCD hour to 12-h BCD hour: 00->12, 13..23 -> 01..11
  function automatic logic [7:0] to_12h(
    input logic [3:0] hi,
    input logic [3:0] lo
  );
    logic [7:0] r;
    r = {hi, lo};
    if (hi == 4'd0 && lo == 4'd0)
      r = {HR12_MID_HI, HR12_MID_LO};
    else if (hi == 4'd1 && lo >= 4'd3)
      r = {4'd0, lo - HR12_SUB_LO};
    else if (hi == 4'd2 && lo <= 4'd1)
      r = {4'd0, lo + HR12_ADD_LO};
    else if (hi == 4'd2)
      r = {4'd1, lo - HR12_SUB_LO};
    return r;
  endfunction

  function automatic tod_t tod_inc(input tod_t t);
    tod_t r;
    r = t;
    if (r.sec_lo != 4'd9) begin
      r.sec_lo = r.sec_lo + 4'd1;
    end else begin
      r.sec_lo = 4'd0;
      if (r.sec_hi != 4'd5) begin
        r.sec_hi = r.sec_hi + 4'd1;
      end else begin
        r.sec_hi = 4'd0;
        if (r.min_lo != 4'd9) begin
          r.min_lo = r.min_lo + 4'd1;
        end else begin
          r.min_lo = 4'd0;
          if (r.min_hi != 4'd5) begin
            r.min_hi = r.min_hi + 4'd1;
          end else begin
            r.min_hi = 4'd0;
            if (r.hr_hi == 4'd2 && r.hr_lo == 4'd3) begin
              r.hr_hi = 4'd0;
              r.hr_lo = 4'd0;
            end else if (r.hr_lo == 4'd9) begin
              r.hr_lo = 4'd0;
              r.hr_hi = r.hr_hi + 4'd1;
            end else begin
              r.hr_lo = r.hr_lo + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/clock3_core_bcd_to_7seg.sv
// BCD digit to active-high seven-segment pattern, bit0 = segment a.
// Codes above 9 turn every segment off.
module bcd_to_7seg
  import clock3_pkg::*;
(
  input  logic [3:0]       bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock3_core.sv
// HH:MM:SS time-of-day core: prescaler, BCD chain, synchronised
// validated time-set load, and 12/24-h seven-segment display.
module clock3_core
  import clock3_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter bit ZEROZ       = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      load_ni,
  input  logic                      mode12_i,
  input  logic [3:0]                ld_hr_hi_i,
  input  logic [3:0]                ld_hr_lo_i,
  input  logic [3:0]                ld_min_hi_i,
  input  logic [3:0]                ld_min_lo_i,
  output logic [SEG_W*N_DIGITS-1:0] seg_o,
  output logic                      pm_o,
  output logic                      tick_o,
  output logic                      load_err_o
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]    sync_q, sync_d;
  logic                      prev_q, prev_d;
  tod_t                      tod_q, tod_d;
  logic [SEG_W*N_DIGITS-1:0] seg_q, seg_d;
  logic                      pm_q, pm_d;
  logic                      fresh_q;

  logic req, ld_ok, hr_ok, do_load, wrap, tick;
  logic [7:0] hr12;
  logic [3:0] disp_hi, disp_lo;
  logic       blank_hi;
  logic [3:0]       dig [N_DIGITS];
  logic [SEG_W-1:0] raw [N_DIGITS];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], load_ni};
    prev_d = sync_q[SYNC_STAGES-1];
    req    = prev_q & ~sync_q[SYNC_STAGES-1];
    hr_ok  = (ld_hr_hi_i < 4'd2 && ld_hr_lo_i <= 4'd9) ||
             (ld_hr_hi_i == 4'd2 && ld_hr_lo_i <= 4'd3);
    ld_ok  = hr_ok && ld_min_hi_i <= 4'd5 &&
             ld_min_lo_i <= 4'd9;
    do_load = req & ld_ok;
    wrap    = (cnt_q == CNT_MAX);
    tick    = wrap & ~do_load;
  end

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    tod_d = tod_q;
    if (do_load || wrap)
      cnt_d = '0;
    if (do_load) begin
      tod_d.hr_hi  = ld_hr_hi_i;
      tod_d.hr_lo  = ld_hr_lo_i;
      tod_d.min_hi = ld_min_hi_i;
      tod_d.min_lo = ld_min_lo_i;
      tod_d.sec_hi = 4'd0;
      tod_d.sec_lo = 4'd0;
    end else if (tick) begin
      tod_d = tod_inc(tod_q);
    end
  end

  assign tick_o     = tick;
  assign load_err_o = req & ~ld_ok;

  always_comb begin
    hr12     = to_12h(tod_q.hr_hi, tod_q.hr_lo);
    disp_hi  = mode12_i ? hr12[7:4] : tod_q.hr_hi;
    disp_lo  = mode12_i ? hr12[3:0] : tod_q.hr_lo;
    blank_hi = ZEROZ && (disp_hi == 4'd0);
    pm_d     = mode12_i &&
               (tod_q.hr_hi == 4'd2 ||
                (tod_q.hr_hi == 4'd1 && tod_q.hr_lo >= 4'd2));
    dig[5] = disp_hi;
    dig[4] = disp_lo;
    dig[3] = tod_q.min_hi;
    dig[2] = tod_q.min_lo;
    dig[1] = tod_q.sec_hi;
    dig[0] = tod_q.sec_lo;
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    bcd_to_7seg u_dec (
      .bcd_i (dig[i]),
      .seg_o (raw[i])
    );
  end

  always_comb begin
    logic [SEG_W-1:0] pat;
    seg_d = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      pat = raw[i];
      if (i == N_DIGITS - 1 && blank_hi)
        pat = SEG_BLANK;
      seg_d[i*SEG_W +: SEG_W] = SEG_ACT_LOW ? ~pat : pat;
    end
  end

  // Until the first clock after reset the live encoding of the
  // zeroed time is shown, so reset reflects the current mode.
  assign seg_o = fresh_q ? seg_d : seg_q;
  assign pm_o  = pm_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      sync_q  <= '1;
      prev_q  <= 1'b1;
      tod_q   <= '0;
      seg_q   <= '0;
      pm_q    <= 1'b0;
      fresh_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      tod_q   <= tod_d;
      seg_q   <= seg_d;
      pm_q    <= pm_d;
      fresh_q <= 1'b0;
    end
  end

endmodule
